// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: single-outstanding load/store front end for the 4-way
// data cache. Handles tag lookup, dirty-victim writeback (4 x 128-bit beats),
// line refill (4 beats) and a replay lookup that completes the access.
module dcache_miss_ctrl (
    input  logic         clk,
    input  logic         rst,
    // CPU request / response
    input  logic         req_valid,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [127:0] resp_data,
    // cache read / write ports
    output logic         c_r,
    output logic         c_w,
    output logic         c_tagcheck,
    output logic         c_nt_read,
    output logic [7:0]   c_r_index,
    output logic [7:0]   c_w_index,
    output logic [17:0]  c_r_tag,
    output logic [17:0]  c_w_tag,
    output logic [5:0]   c_r_line,
    output logic [5:0]   c_w_line,
    output logic [127:0] c_w_data,
    output logic [1:0]   c_w_way,
    output logic [1:0]   c_nt_way,
    input  logic         c_hit,
    input  logic         c_dirty,
    input  logic [1:0]   c_way,
    input  logic [17:0]  c_tag_out,
    input  logic [127:0] c_data_out,
    // memory port
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic         mem_rvalid,
    input  logic [127:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_RD,
        WB_WR,
        FILL_REQ,
        FILL,
        REPLAY
    } state_t;

    state_t       state_q, state_d;
    logic [17:0]  tag_q, tag_d;
    logic [7:0]   index_q, index_d;
    logic [1:0]   off_q, off_d;
    logic         we_q, we_d;
    logic [127:0] wdata_q, wdata_d;
    logic [1:0]   victim_way_q, victim_way_d;
    logic [17:0]  victim_tag_q, victim_tag_d;
    logic [1:0]   beat_q, beat_d;
    logic [127:0] wb_data_q, wb_data_d;
    logic         wb_held_q, wb_held_d;

    // Byte offset within a beat never reaches the cache or memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[3:0];

    // Writeback beat: live cache data on the first WB_WR cycle, the captured
    // copy on every later cycle of a stalled handshake.
    logic [127:0] wb_word;
    assign wb_word = wb_held_q ? wb_data_q : c_data_out;

    // State and latched-request registers, cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            index_q      <= '0;
            off_q        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            victim_way_q <= '0;
            victim_tag_q <= '0;
            beat_q       <= '0;
            wb_data_q    <= '0;
            wb_held_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            off_q        <= off_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            victim_way_q <= victim_way_d;
            victim_tag_q <= victim_tag_d;
            beat_q       <= beat_d;
            wb_data_q    <= wb_data_d;
            wb_held_q    <= wb_held_d;
        end
    end

    // Next-state and output decode; every output idles at zero.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        off_d        = off_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        victim_way_d = victim_way_q;
        victim_tag_d = victim_tag_q;
        beat_d       = beat_q;
        wb_data_d    = wb_data_q;
        wb_held_d    = 1'b0;

        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        c_r          = 1'b0;
        c_w          = 1'b0;
        c_tagcheck   = 1'b0;
        c_nt_read    = 1'b0;
        c_r_index    = '0;
        c_w_index    = '0;
        c_r_tag      = '0;
        c_w_tag      = '0;
        c_r_line     = '0;
        c_w_line     = '0;
        c_w_data     = '0;
        c_w_way      = '0;
        c_nt_way     = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tag_d      = req_addr[31:14];
                    index_d    = req_addr[13:6];
                    off_d      = req_addr[5:4];
                    we_d       = req_we;
                    wdata_d    = req_wdata;
                    c_r        = 1'b1;
                    c_r_index  = req_addr[13:6];
                    c_r_tag    = req_addr[31:14];
                    c_r_line   = {req_addr[5:4], 4'b0};
                    c_tagcheck = req_we;
                    state_d    = LOOKUP;
                end
            end

            LOOKUP: begin
                if (c_hit) begin
                    resp_valid = 1'b1;
                    if (we_q) begin
                        c_w       = 1'b1;
                        c_w_way   = c_way;
                        c_w_tag   = tag_q;
                        c_w_index = index_q;
                        c_w_line  = {off_q, 4'b0};
                        c_w_data  = wdata_q;
                    end else begin
                        resp_data = c_data_out;
                    end
                    state_d = IDLE;
                end else begin
                    victim_way_d = c_way;
                    victim_tag_d = c_tag_out;
                    beat_d       = '0;
                    state_d      = c_dirty ? WB_RD : FILL_REQ;
                end
            end

            WB_RD: begin
                c_r       = 1'b1;
                c_nt_read = 1'b1;
                c_nt_way  = victim_way_q;
                c_r_index = index_q;
                c_r_line  = {beat_q, 4'b0};
                state_d   = WB_WR;
            end

            WB_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_tag_q, index_q, beat_q, 4'b0};
                mem_wdata = wb_word;
                if (mem_ready) begin
                    beat_d  = beat_q + 2'd1;
                    state_d = (beat_q == 2'd3) ? FILL_REQ : WB_RD;
                end else begin
                    wb_held_d = 1'b1;
                    wb_data_d = wb_word;
                end
            end

            FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, index_q, 6'b0};
                if (mem_ready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end

            FILL: begin
                if (mem_rvalid) begin
                    c_w       = 1'b1;
                    c_w_way   = victim_way_q;
                    c_w_tag   = tag_q;
                    c_w_index = index_q;
                    c_w_line  = {beat_q, 4'b0};
                    c_w_data  = mem_rdata;
                    beat_d    = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = REPLAY;
                    end
                end
            end

            REPLAY: begin
                c_r        = 1'b1;
                c_r_index  = index_q;
                c_r_tag    = tag_q;
                c_r_line   = {off_q, 4'b0};
                c_tagcheck = we_q;
                state_d    = LOOKUP;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a behavioural 4-way cache,
// a configurable-latency memory and queue-based scoreboards.
module tb_dcache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_we, req_ready;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         c_r, c_w, c_tagcheck, c_nt_read;
    logic [7:0]   c_r_index, c_w_index;
    logic [17:0]  c_r_tag, c_w_tag;
    logic [5:0]   c_r_line, c_w_line;
    logic [127:0] c_w_data;
    logic [1:0]   c_w_way, c_nt_way;
    logic         c_hit, c_dirty;
    logic [1:0]   c_way;
    logic [17:0]  c_tag_out;
    logic [127:0] c_data_out;
    logic         mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    dcache_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .c_r(c_r), .c_w(c_w), .c_tagcheck(c_tagcheck), .c_nt_read(c_nt_read),
        .c_r_index(c_r_index), .c_w_index(c_w_index), .c_r_tag(c_r_tag), .c_w_tag(c_w_tag),
        .c_r_line(c_r_line), .c_w_line(c_w_line), .c_w_data(c_w_data),
        .c_w_way(c_w_way), .c_nt_way(c_nt_way),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_way(c_way), .c_tag_out(c_tag_out), .c_data_out(c_data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic is_load; logic [127:0] data; int lat; } resp_t;
    typedef struct { logic [7:0] idx; logic [1:0] way; logic [5:0] line; logic [17:0] tag; logic [127:0] data; } cw_t;
    typedef struct { logic [31:0] addr; logic [127:0] data; } mw_t;

    resp_t       rq[$];
    cw_t         wq[$];
    mw_t         mwq[$];
    logic [31:0] fq[$];

    // behavioural cache contents
    logic [17:0]  m_tag   [256][4];
    logic         m_val   [256][4];
    logic         m_dirty [256][4];
    logic [127:0] m_data  [256][4][4];

    int total = 0;
    int bad   = 0;
    int cyc = 0, accept_cyc = 0;
    int ready_delay = 0, fill_gap = 0, mwait = 0, fill_left = 0, gap_cnt = 0;
    int wcount = 0, mreq_cycles = 0, resp_cycles = 0;
    logic [31:0]  fill_base = '0;
    logic         tc_q = 1'b0, stray_rv = 1'b0, hold_prev = 1'b0;
    logic [191:0] prev_mem = '0;
    logic         nxt_hit = 1'b0, nxt_dirty = 1'b0;
    logic [1:0]   nxt_way = '0;
    logic [17:0]  nxt_tag = '0;
    logic [127:0] nxt_data = '0;

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1111};
    endfunction

    function automatic logic [127:0] line_pat(input logic [7:0] idx, input logic [1:0] way, input logic [1:0] b);
        return {4{8'hC0, idx, 6'b0, way, 6'b0, b}};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [1:0] way, input logic [17:0] tag, input logic dirty);
        m_val[idx][way]   = 1'b1;
        m_tag[idx][way]   = tag;
        m_dirty[idx][way] = dirty;
        for (int unsigned b = 0; b < 4; b++) m_data[idx][way][b] = line_pat(idx, way, b[1:0]);
    endtask

    task automatic push_fill(input logic [31:0] a, input logic [1:0] way);
        logic [1:0] bb;
        fq.push_back({a[31:6], 6'b0});
        for (int unsigned b = 0; b < 4; b++) begin
            bb = b[1:0];
            wq.push_back('{idx: a[13:6], way: way, line: {bb, 4'b0}, tag: a[31:14],
                           data: mem_word({a[31:6], bb, 4'b0})});
        end
    endtask

    task automatic push_wb(input logic [17:0] vt, input logic [7:0] idx, input logic [1:0] way);
        logic [1:0] bb;
        for (int unsigned b = 0; b < 4; b++) begin
            bb = b[1:0];
            mwq.push_back('{addr: {vt, idx, bb, 4'b0}, data: line_pat(idx, way, bb)});
        end
    endtask

    // Sample DUT outputs mid-cycle: scoreboards, cache model update, memory handshakes.
    task automatic observe();
        resp_t r; cw_t w; mw_t m; logic [31:0] fa;
        logic hit, vfound; logic [1:0] hw, vw; logic [191:0] cur_mem;
        if (!rst) begin
            cur_mem = {30'b0, mem_req, mem_we, mem_addr, mem_wdata};
            if (hold_prev) chk("mem_hold", cur_mem, prev_mem);
            hold_prev = mem_req && !mem_ready;
            prev_mem  = cur_mem;
            if (mem_req) mreq_cycles++;
            if (req_valid && req_ready) accept_cyc = cyc;

            if (resp_valid) begin
                resp_cycles++;
                chk("resp_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("resp_latency", cyc - accept_cyc, r.lat);
                    if (r.is_load) chk("resp_data", resp_data, r.data);
                end
            end

            if (c_w) begin
                wcount++;
                chk("cw_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("cw_fields", {c_w_index, c_w_way, c_w_line, c_w_tag}, {w.idx, w.way, w.line, w.tag});
                    chk("cw_data", c_w_data, w.data);
                end
                m_data[c_w_index][c_w_way][c_w_line[5:4]] = c_w_data;
                m_tag[c_w_index][c_w_way]   = c_w_tag;
                m_val[c_w_index][c_w_way]   = 1'b1;
                m_dirty[c_w_index][c_w_way] = tc_q;
            end
            tc_q = c_r && c_tagcheck;

            nxt_data = {$urandom, $urandom, $urandom, $urandom};
            if (c_r) begin
                if (c_nt_read) begin
                    nxt_hit   = 1'b0;
                    nxt_way   = c_nt_way;
                    nxt_tag   = m_tag[c_r_index][c_nt_way];
                    nxt_dirty = 1'b0;
                    nxt_data  = m_data[c_r_index][c_nt_way][c_r_line[5:4]];
                end else begin
                    hit = 1'b0; hw = '0; vfound = 1'b0; vw = '0;
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (!hit && m_val[c_r_index][k] && m_tag[c_r_index][k] == c_r_tag) begin
                            hit = 1'b1; hw = k[1:0];
                        end
                        if (!vfound && !m_val[c_r_index][k]) begin
                            vfound = 1'b1; vw = k[1:0];
                        end
                    end
                    if (!req_ready) chk("replay_hit", hit, 1);
                    nxt_hit = hit;
                    if (hit) begin
                        nxt_way   = hw;
                        nxt_tag   = m_tag[c_r_index][hw];
                        nxt_dirty = m_dirty[c_r_index][hw];
                        nxt_data  = m_data[c_r_index][hw][c_r_line[5:4]];
                    end else begin
                        nxt_way   = vw;
                        nxt_tag   = m_tag[c_r_index][vw];
                        nxt_dirty = m_val[c_r_index][vw] && m_dirty[c_r_index][vw];
                    end
                end
            end

            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    chk("wb_expected", mwq.size() != 0, 1);
                    if (mwq.size() != 0) begin
                        m = mwq.pop_front();
                        chk("wb_addr", mem_addr, m.addr);
                        chk("wb_data", mem_wdata, m.data);
                    end
                end else begin
                    chk("fill_expected", fq.size() != 0, 1);
                    if (fq.size() != 0) begin
                        fa = fq.pop_front();
                        chk("fill_addr", mem_addr, fa);
                    end
                    fill_left = 4;
                    fill_base = mem_addr;
                    gap_cnt   = 0;
                end
            end
            if (mem_req && !mem_ready) mwait++;
            else mwait = 0;
        end
    endtask

    // Apply cache/memory responses just after the active edge.
    task automatic drive_env();
        cyc++;
        c_hit      = nxt_hit;
        c_dirty    = nxt_dirty;
        c_way      = nxt_way;
        c_tag_out  = nxt_tag;
        c_data_out = nxt_data;
        mem_ready  = mem_req && (mwait >= ready_delay);
        if (fill_left > 0 && gap_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(fill_base + 32'((4 - fill_left) * 16));
            fill_left--;
            gap_cnt = fill_gap;
        end else begin
            mem_rvalid = stray_rv;
            mem_rdata  = {4{32'hBAD0_BAD0}};
            if (gap_cnt > 0) gap_cnt--;
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive_env();
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [127:0] wd,
                         input logic [127:0] ed, input int lat);
        rq.push_back('{is_load: !we, data: ed, lat: lat});
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int unsigned i = 0; i < 300 && rq.size() != 0; i++) step();
        chk("resp_timeout", rq.size() == 0, 1);
        chk("queues_drained", {wq.size() == 0, mwq.size() == 0, fq.size() == 0}, 3'b111);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, mr0, rs0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        c_hit = 1'b0; c_dirty = 1'b0; c_way = '0; c_tag_out = '0; c_data_out = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int unsigned s = 0; s < 256; s++)
            for (int unsigned k = 0; k < 4; k++) begin
                m_val[s][k] = 1'b0; m_tag[s][k] = '0; m_dirty[s][k] = 1'b0;
            end

        // reset state
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_ctrl", {resp_valid, c_r, c_w, c_tagcheck, c_nt_read, c_r_index, c_w_index, c_r_tag, c_w_tag,
                         c_r_line, c_w_line, c_w_way, c_nt_way, mem_req, mem_we, mem_addr}, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_cw_data", c_w_data, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // load hit, with a stray fill beat that must be ignored
        preload(8'h12, 2'd2, 18'h03A5C, 1'b0);
        m_data[8'h12][2][2] = {16{8'hA5}};
        stray_rv = 1'b1;
        issue(32'h0E97_04A0, 1'b0, '0, {16{8'hA5}}, 1);
        stray_rv = 1'b0;

        // store hit, read back, neighbouring beat
        wq.push_back('{idx: 8'h12, way: 2'd2, line: 6'h20, tag: 18'h03A5C, data: {8{16'hDEAD}}});
        issue(32'h0E97_04A0, 1'b1, {8{16'hDEAD}}, '0, 1);
        issue(32'h0E97_04A0, 1'b0, '0, {8{16'hDEAD}}, 1);
        issue(32'h0E97_0490, 1'b0, '0, line_pat(8'h12, 2'd2, 2'd1), 1);

        // clean load miss, zero-wait memory
        push_fill(32'h0000_1040, 2'd0);
        issue(32'h0000_1040, 1'b0, '0, mem_word(32'h0000_1040), 8);

        // clean store miss, then read back
        push_fill(32'h0000_20A0, 2'd0);
        wq.push_back('{idx: 8'h82, way: 2'd0, line: 6'h20, tag: 18'h0, data: {4{32'h1234_5678}}});
        issue(32'h0000_20A0, 1'b1, {4{32'h1234_5678}}, '0, 8);
        issue(32'h0000_20A0, 1'b0, '0, {4{32'h1234_5678}}, 1);

        // dirty miss: victim tag 0x2, index 0x01
        preload(8'h01, 2'd0, 18'h00002, 1'b1);
        preload(8'h01, 2'd1, 18'h00010, 1'b0);
        preload(8'h01, 2'd2, 18'h00011, 1'b0);
        preload(8'h01, 2'd3, 18'h00012, 1'b0);
        push_wb(18'h00002, 8'h01, 2'd0);
        push_fill(32'h0001_4050, 2'd0);
        issue(32'h0001_4050, 1'b0, '0, mem_word(32'h0001_4050), 16);

        // backpressure, clean miss: ready low 5 cycles, beats 3 cycles apart
        ready_delay = 5; fill_gap = 2;
        push_fill(32'h0000_3080, 2'd0);
        issue(32'h0000_3080, 1'b0, '0, mem_word(32'h0000_3080), 19);

        // backpressure, dirty miss: writeback data must hold while stalled
        ready_delay = 2; fill_gap = 1;
        preload(8'h03, 2'd0, 18'h00007, 1'b1);
        preload(8'h03, 2'd1, 18'h00020, 1'b0);
        preload(8'h03, 2'd2, 18'h00021, 1'b0);
        preload(8'h03, 2'd3, 18'h00022, 1'b0);
        push_wb(18'h00007, 8'h03, 2'd0);
        push_fill(32'h0002_40F0, 2'd0);
        issue(32'h0002_40F0, 1'b0, '0, mem_word(32'h0002_40F0), 29);

        // reset while waiting for fill beat 2
        ready_delay = 0; fill_gap = 2;
        push_fill(32'h0000_10C0, 2'd0);
        rq.push_back('{is_load: 1'b1, data: mem_word(32'h0000_10C0), lat: 10});
        w0 = wcount;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_10C0;
        step();
        req_valid = 1'b0; req_addr = '0;
        for (int unsigned i = 0; i < 50 && (wcount - w0) < 2; i++) step();
        chk("fill_progress", wcount - w0, 2);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {req_ready, resp_valid, mem_req, c_w, c_r}, 5'b10000);
        rq.delete(); wq.delete(); fq.delete(); mwq.delete();
        fill_left = 0; gap_cnt = 0; mwait = 0; hold_prev = 1'b0;
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        step();
        rst = 1'b0;
        mr0 = mreq_cycles; rs0 = resp_cycles;
        for (int unsigned i = 0; i < 10; i++) step();
        chk("no_mem_after_rst", mreq_cycles - mr0, 0);
        chk("no_resp_after_rst", resp_cycles - rs0, 0);
        chk("idle_after_rst", req_ready, 1);

        // normal operation resumes after the abort
        issue(32'h0E97_04A0, 1'b0, '0, {8{16'hDEAD}}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
